uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  Receive side of the full-duplex UART; sits directly downstream of the transmitter on the serial line.
//  Deserialises frames of 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
//  The parity bit equals the XOR of the 8 data bits.
//  Presents each received byte with a one-cycle valid strobe plus parity and framing error flags.
// PARAMETERS
//  CLKS_PER_BIT  5208  clock cycles per bit period (50 MHz / 9600 baud); must be >= 8
//  HALF_BIT      CLKS_PER_BIT/2  cycles from start-bit edge to its mid-point (integer division)
// PORTS
//  Clock_2br   in   1  system clock, all logic on rising edge
//  Reset       in   1  synchronous, active-high reset
//  Rx          in   1  asynchronous serial line, idles high
//  Data        out  8  last received byte, LSB = first data bit
//  Valid       out  1  one-cycle pulse: Data/Parity_Err/Frame_Err updated this cycle
//  Parity_Err  out  1  1 = XOR(Data) != received parity bit (held until next Valid)
//  Frame_Err   out  1  1 = stop bit sampled low (held until next Valid)
//  Busy        out  1  1 whenever FSM is not in IDLE
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  - Rx passes through a 2-flop synchroniser (rx_s) before any use; rx_s resets to 1.
//  - Reset (sampled on clock edge, any state, incl. mid-frame): FSM->IDLE, counters=0, Data=0x00,
//    Valid=0, Parity_Err=0, Frame_Err=0, Busy=0, shift register cleared. Partial frame is discarded.
//  - Bit-timing counter: 0..CLKS_PER_BIT-1, cleared on every state change.
//  - States:
//    IDLE:    rx_s==0 -> START.
//    START:   at count HALF_BIT-1, sample rx_s. 1 -> IDLE (glitch, no Valid). 0 -> DATA, bit_idx=0.
//    DATA:    at count CLKS_PER_BIT-1, shift rx_s into bit[bit_idx], bit_idx++.
//             After bit 7 -> PARITY.
//    PARITY:  at count CLKS_PER_BIT-1, capture parity bit -> STOP.
//    STOP:    at count CLKS_PER_BIT-1, sample stop bit. In that cycle register Data, Parity_Err, Frame_Err;
//             Valid=1 on the following cycle only.
//             Stop=1 -> IDLE. Stop=0 -> BREAK.
//    BREAK:   wait until rx_s==1, then IDLE. A line held low never produces further frames.
//  - Samples are taken at bit mid-points. STOP returns to IDLE half a bit early so back-to-back frames
//    are accepted with zero idle time.
//  - Data is updated and Valid pulses even when Parity_Err or Frame_Err is set.
//  - Latency: Valid rises 2 + HALF_BIT + 10*CLKS_PER_BIT cycles (+/-2) after the Rx falling edge.
//  - Simultaneous Reset and stop-bit sample: reset wins, no Valid.
//  - Busy=1 from the cycle after START entry until return to IDLE.
//  - Unused state encodings -> IDLE.
// TESTING (sim with CLKS_PER_BIT=16; frames driven bit-accurately at 16 clk/bit)
//  1 Frame 0xA5, parity 0, stop 1 -> single Valid pulse, Data=0xA5, Parity_Err=0, Frame_Err=0,
//    at 2+8+160 +/-2 clks.
//  2 Frame 0x01 with parity bit 0 (wrong) -> Valid, Data=0x01, Parity_Err=1, Frame_Err=0.
//  3 Frame 0x3C with stop bit 0, line held low 40 clks then high -> Valid, Frame_Err=1;
//    no second Valid while low; then frame 0x55 -> Data=0x55, Frame_Err=0.
//  4 Rx low for 4 clks then high -> no Valid; FSM back in IDLE, Busy=0 within HALF_BIT+3 clks.
//  5 Back-to-back 0x00 then 0xFF, no idle gap -> two Valid pulses, Data 0x00 then 0xFF, no errors.
//  6 Reset asserted one cycle during DATA bit 4 of 0x81, then clean frame 0x7E -> outputs at reset
//    values; first Valid carries Data=0x7E.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8E1 UART receiver with mid-bit sampling, parity and framing error flags
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       Clock_2br,
    input  logic       Reset,
    input  logic       Rx,
    output logic [7:0] Data,
    output logic       Valid,
    output logic       Parity_Err,
    output logic       Frame_Err,
    output logic       Busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t          state, state_n;
    logic            rx_meta, rx_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            par_bit;
    logic            tick, half, done;

    assign tick = cnt == CW'(CLKS_PER_BIT - 1);
    assign half = cnt == CW'(HALF_BIT - 1);
    assign done = state == STOP && tick;
    assign Busy = state != IDLE;

    // two-flop synchroniser for the asynchronous line; idles high
    always_ff @(posedge Clock_2br) begin
        if (Reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
        end
    end

    // state register
    always_ff @(posedge Clock_2br) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    // next-state logic; STOP leaves at mid stop bit so back-to-back frames are caught
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = rx_s ? IDLE : START;
            START:   state_n = half ? (rx_s ? IDLE : DATA) : START;
            DATA:    state_n = (tick && bit_idx == 3'd7) ? PARITY : DATA;
            PARITY:  state_n = tick ? STOP : PARITY;
            STOP:    state_n = tick ? (rx_s ? IDLE : BREAK) : STOP;
            BREAK:   state_n = rx_s ? IDLE : BREAK;
            default: state_n = IDLE;
        endcase
    end

    // bit timer, bit index, data shifter and parity capture
    always_ff @(posedge Clock_2br) begin
        if (Reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else begin
            cnt     <= (state_n != state || tick || state == IDLE) ? '0 : cnt + 1'b1;
            bit_idx <= (state != DATA) ? 3'd0 : bit_idx + 3'(tick);
            if (state == DATA && tick) shift <= {rx_s, shift[7:1]};
            if (state == PARITY && tick) par_bit <= rx_s;
        end
    end

    // result registers, updated at the stop-bit sample; Valid follows one cycle later
    always_ff @(posedge Clock_2br) begin
        if (Reset) begin
            Data       <= '0;
            Valid      <= 1'b0;
            Parity_Err <= 1'b0;
            Frame_Err  <= 1'b0;
        end else begin
            Valid <= done;
            if (done) begin
                Data       <= shift;
                Parity_Err <= (^shift) ^ par_bit;
                Frame_Err  <= ~rx_s;
            end
        end
    end
endmodule
